sram_1rw_rmw_wrapper: RTL

//  Parametrised single-port (1RW) SRAM wrapper for FPGA builds with true per-bit write masking.

---
 rtl/sram_1rw_rmw_wrapper_pkg.sv | 12 +
 rtl/sram_1rw_rmw_wrapper_bram.sv | 28 ++
 rtl/sram_1rw_rmw_wrapper.sv | 126 ++++++++++++
 3 files changed

// File: rtl/sram_1rw_rmw_wrapper_pkg.sv
// Shared definitions for the 1RW SRAM wrappers: access encodings and FSM states.
package sram_1rw_rmw_wrapper_pkg;

   localparam logic SRAM_RD = 1'b1;
   localparam logic SRAM_WR = 1'b0;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/sram_1rw_rmw_wrapper_bram.sv
// Inferred simple-dual-port block RAM: write-only port A, registered read-first port B.
module sram_sdp_bram #(
   parameter int DEPTH  = 512,
   parameter int WIDTH  = 32,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wea,
   input  logic [ADDR_W-1:0] addra,
   input  logic [WIDTH-1:0]  dina,
   input  logic              enb,
   input  logic [ADDR_W-1:0] addrb,
   output logic [WIDTH-1:0]  doutb
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Non-blocking update of both ports gives read-first behaviour on a same-address collision.
   always_ff @(posedge clk) begin
      if (wea) begin
         mem[addra] <= dina;
      end
      if (enb) begin
         doutb <= mem[addrb];
      end
   end

endmodule

// File: rtl/sram_1rw_rmw_wrapper.sv
// 1RW SRAM wrapper with per-bit write masking via read-modify-write and a post-reset clear.
module sram_1rw_rmw_wrapper
   import sram_1rw_rmw_wrapper_pkg::*;
#(
   parameter int DEPTH  = 512,
   parameter int WIDTH  = 32,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              MEMCLK,
   input  logic              RESET_N,
   input  logic              CE,
   input  logic [ADDR_W-1:0] A,
   input  logic              RDWEN,
   input  logic [WIDTH-1:0]  BW,
   input  logic [WIDTH-1:0]  DIN,
   output logic [WIDTH-1:0]  DOUT,
   output logic              READY
);

   localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W+1)'(1);

   state_t              state_q, state_d;
   logic [ADDR_W:0]     init_cnt_q, init_cnt_d;
   logic                accept, rd_issue, wr_issue;
   logic                s1_vld_q;
   logic [ADDR_W-1:0]   s1_a_q;
   logic [WIDTH-1:0]    s1_bw_q, s1_din_q;
   logic                fwd_sel_q;
   logic [WIDTH-1:0]    fwd_d_q;
   logic                rd_q, dout_vld_q;
   logic [WIDTH-1:0]    dout_hold_q;
   logic                wea;
   logic [ADDR_W-1:0]   addra;
   logic [WIDTH-1:0]    dina, doutb, lookup, merged;

   assign READY    = (state_q == ST_RUN);
   assign accept   = READY && CE;
   assign rd_issue = accept && (RDWEN == SRAM_RD);
   assign wr_issue = accept && (RDWEN == SRAM_WR);

   // Data returned by port B, overridden by the write that committed while it was being read.
   assign lookup = fwd_sel_q ? fwd_d_q : doutb;
   assign merged = (lookup & ~s1_bw_q) | (s1_din_q & s1_bw_q);
   assign DOUT   = !dout_vld_q ? '0 : (rd_q ? lookup : dout_hold_q);

   always_ff @(posedge MEMCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= ST_INIT;
         init_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
      end
   end

   // INIT owns port A to zero every entry; afterwards port A only commits stage-1 writes.
   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      wea        = 1'b0;
      addra      = s1_a_q;
      dina       = merged;
      case (state_q)
         ST_INIT: begin
            wea        = 1'b1;
            addra      = init_cnt_q[ADDR_W-1:0];
            dina       = '0;
            init_cnt_d = init_cnt_q + ONE_CNT;
            if (init_cnt_q == LAST_CNT) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            wea = s1_vld_q;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   always_ff @(posedge MEMCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         s1_vld_q   <= 1'b0;
         fwd_sel_q  <= 1'b0;
         rd_q       <= 1'b0;
         dout_vld_q <= 1'b0;
      end else begin
         s1_vld_q  <= wr_issue;
         fwd_sel_q <= accept && s1_vld_q && (s1_a_q == A);
         rd_q      <= rd_issue;
         if (rd_issue) begin
            dout_vld_q <= 1'b1;
         end
      end
   end

   // Payload registers need no reset; their valid flags gate every use.
   always_ff @(posedge MEMCLK) begin
      fwd_d_q <= merged;
      if (wr_issue) begin
         s1_a_q   <= A;
         s1_bw_q  <= BW;
         s1_din_q <= DIN;
      end
      if (rd_q) begin
         dout_hold_q <= lookup;
      end
   end

   sram_sdp_bram #(
      .DEPTH  (DEPTH),
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
   ) u_bram (
      .clk   (MEMCLK),
      .wea   (wea),
      .addra (addra),
      .dina  (dina),
      .enb   (accept),
      .addrb (A),
      .doutb (doutb)
   );

endmodule
